// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bank
// Purpose  : Bank of independent input debouncers. Each channel synchronises
//            a raw asynchronous input, then accepts a new level only after
//            the synchronised value has differed from the current clean level
//            for a programmable number of consecutive enabled cycles.
//            Registered rise/fall pulses, an OR-reduced any_edge pulse and
//            sticky, individually clearable edge-seen flags are provided.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1         sole clock, rising edge
//   rst_n      in   1         synchronous active-low reset
//   en         in   1         debounce enable (low freezes filtering)
//   width      in   CNT_W     stability threshold in cycles (0 acts as 1)
//   dirty      in   CHANNELS  raw asynchronous inputs
//   clean      out  CHANNELS  debounced levels
//   rise       out  CHANNELS  one-cycle pulse on clean 0->1
//   fall       out  CHANNELS  one-cycle pulse on clean 1->0
//   flags      out  CHANNELS  sticky edge-seen status
//   clr_flags  in   CHANNELS  per-bit clear for flags
//   any_edge   out  1         OR of all rise and fall bits
// ============================================================================
module debounce_bank #(
  parameter int unsigned          CHANNELS    = 4,
  parameter int unsigned          CNT_W       = 24,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]  RESET_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CNT_W-1:0]    width,
  input  logic [CHANNELS-1:0] dirty,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] flags,
  input  logic [CHANNELS-1:0] clr_flags,
  output logic                any_edge
);

  // --------------------------------------------------------------------------
  // Input synchroniser. Stage 0 samples the raw input; the last stage feeds
  // the filter. It keeps running while en is low so that the filter sees an
  // up-to-date level as soon as it is re-enabled.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  sync_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dirty};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Threshold. Comparing against W_eff-1 lets the counter accept on the
  // W_eff-th differing cycle and keeps it from ever reaching all-ones, so it
  // cannot wrap. A zero width behaves exactly like a width of one.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] thr_m1;

  assign thr_m1 = (width == '0) ? '0 : (width - CNT_W'(1));

  // --------------------------------------------------------------------------
  // Output state
  // --------------------------------------------------------------------------
  logic [CHANNELS-1:0] clean_q;
  logic [CHANNELS-1:0] clean_d;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] fall_d;
  logic [CHANNELS-1:0] flags_q;
  logic [CHANNELS-1:0] flags_d;
  logic                any_edge_q;
  logic                any_edge_d;

  // --------------------------------------------------------------------------
  // Per-channel stability counters
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_nx;

    // The counter returns to zero whenever the filter is disabled, the
    // input agrees with the clean level, or a new level is accepted. Using
    // >= rather than == means a threshold lowered mid-count takes effect on
    // the very next edge instead of being skipped over.
    always_comb begin
      cnt_d    = '0;
      clean_nx = clean_q[i];
      if (en && (sync_s[i] != clean_q[i])) begin
        if (cnt_q >= thr_m1) begin
          clean_nx = sync_s[i];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign clean_d[i] = clean_nx;
  end : g_ch

  // --------------------------------------------------------------------------
  // Edge detection is done on the next-state value so the pulses register
  // on the same edge as the new clean level.
  // --------------------------------------------------------------------------
  assign rise_d     = clean_d & ~clean_q;
  assign fall_d     = ~clean_d & clean_q;
  assign any_edge_d = |(rise_d | fall_d);

  // A set arriving together with a clear wins, so no edge is ever lost.
  assign flags_d    = (flags_q & ~clr_flags) | rise_d | fall_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clean_q    <= RESET_VAL;
      rise_q     <= '0;
      fall_q     <= '0;
      flags_q    <= '0;
      any_edge_q <= 1'b0;
    end else begin
      clean_q    <= clean_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      flags_q    <= flags_d;
      any_edge_q <= any_edge_d;
    end
  end

  assign clean    = clean_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign flags    = flags_q;
  assign any_edge = any_edge_q;

endmodule : debounce_bank
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_bank
// Purpose  : Directed self-checking bench for debounce_bank with the default
//            configuration (4 channels, 24-bit counters, 2 sync stages,
//            all-zero reset level).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned CW = 24;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [CW-1:0] width;
  logic [CH-1:0] dirty;
  logic [CH-1:0] clean;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] flags;
  logic [CH-1:0] clr_flags;
  logic          any_edge;

  int n_pass  = 0;
  int n_total = 0;

  debounce_bank #(
    .CHANNELS    (CH),
    .CNT_W       (CW),
    .SYNC_STAGES (2),
    .RESET_VAL   ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .width     (width),
    .dirty     (dirty),
    .clean     (clean),
    .rise      (rise),
    .fall      (fall),
    .flags     (flags),
    .clr_flags (clr_flags),
    .any_edge  (any_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return every channel to 0 and clear all flags.
  task automatic quiesce();
    en    = 1'b1;
    width = CW'(1);
    dirty = '0;
    repeat (8) tick();
    clr_flags = '1;
    tick();
    clr_flags = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_total++;
    if ({clean, rise, fall, flags, any_edge} !== 17'h0)
      $display("FAIL reset_state: got %h expected %h", {clean, rise, fall, flags, any_edge}, 17'h0);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  // width=4: step on dirty[0] is accepted exactly 6 edges after first sample
  task automatic test_basic_rise();
    width = CW'(4);
    dirty = 4'b0001;
    repeat (5) tick();
    n_total++;
    if (clean !== 4'b0000 || rise !== 4'b0000)
      $display("FAIL basic_early: clean %b rise %b expected 0000 0000", clean, rise);
    else n_pass++;
    tick();
    n_total++;
    if ({clean, rise, flags, any_edge} !== {4'b0001, 4'b0001, 4'b0001, 1'b1})
      $display("FAIL basic_edge6: clean %b rise %b flags %b any %b expected 0001 0001 0001 1",
               clean, rise, flags, any_edge);
    else n_pass++;
    tick();
    n_total++;
    if ({clean, rise, fall, any_edge} !== {4'b0001, 4'b0000, 4'b0000, 1'b0})
      $display("FAIL basic_pulse_end: clean %b rise %b fall %b any %b expected 0001 0000 0000 0",
               clean, rise, fall, any_edge);
    else n_pass++;
    quiesce();
  endtask

  // width=4: a 3-cycle pulse is rejected and the count restarts from zero
  task automatic test_glitch();
    logic [CH-1:0] seen;
    seen  = '0;
    width = CW'(4);
    dirty = 4'b0010;
    repeat (3) begin tick(); seen |= rise | fall; end
    dirty = 4'b0000;
    repeat (8) begin tick(); seen |= rise | fall; end
    n_total++;
    if (clean !== 4'b0000 || seen !== 4'b0000)
      $display("FAIL glitch_reject: clean %b edges %b expected 0000 0000", clean, seen);
    else n_pass++;
    dirty = 4'b0010;
    repeat (5) tick();
    n_total++;
    if (clean !== 4'b0000)
      $display("FAIL glitch_restart_early: clean %b expected 0000", clean);
    else n_pass++;
    tick();
    n_total++;
    if (clean !== 4'b0010 || rise !== 4'b0010)
      $display("FAIL glitch_restart_full: clean %b rise %b expected 0010 0010", clean, rise);
    else n_pass++;
    quiesce();
  endtask

  // width=0 and width=1 both give SYNC_STAGES+1 edges of latency
  task automatic test_width_zero_one();
    width = CW'(0);
    dirty = 4'b0100;
    repeat (2) tick();
    n_total++;
    if (clean !== 4'b0000)
      $display("FAIL w0_early: clean %b expected 0000", clean);
    else n_pass++;
    tick();
    n_total++;
    if (clean !== 4'b0100 || rise !== 4'b0100)
      $display("FAIL w0_edge3: clean %b rise %b expected 0100 0100", clean, rise);
    else n_pass++;
    width = CW'(1);
    dirty = 4'b0000;
    repeat (2) tick();
    n_total++;
    if (clean !== 4'b0100)
      $display("FAIL w1_early: clean %b expected 0100", clean);
    else n_pass++;
    tick();
    n_total++;
    if (clean !== 4'b0000 || fall !== 4'b0100 || rise !== 4'b0000)
      $display("FAIL w1_edge3: clean %b fall %b rise %b expected 0000 0100 0000", clean, fall, rise);
    else n_pass++;
    quiesce();
  endtask

  // all channels switch together; clear coinciding with a set keeps the flag
  task automatic test_simultaneous_flags();
    width = CW'(2);
    dirty = 4'b1111;
    repeat (3) tick();
    n_total++;
    if (clean !== 4'b0000)
      $display("FAIL simul_early: clean %b expected 0000", clean);
    else n_pass++;
    tick();
    n_total++;
    if ({clean, rise, flags, any_edge} !== {4'b1111, 4'b1111, 4'b1111, 1'b1})
      $display("FAIL simul_rise: clean %b rise %b flags %b any %b expected 1111 1111 1111 1",
               clean, rise, flags, any_edge);
    else n_pass++;
    dirty = 4'b0000;
    repeat (3) tick();
    clr_flags = 4'b0001;
    tick();
    clr_flags = 4'b0000;
    n_total++;
    if ({clean, fall, flags} !== {4'b0000, 4'b1111, 4'b1111})
      $display("FAIL simul_fall_setclr: clean %b fall %b flags %b expected 0000 1111 1111",
               clean, fall, flags);
    else n_pass++;
    clr_flags = 4'b0010;
    tick();
    clr_flags = 4'b0000;
    n_total++;
    if (flags !== 4'b1101)
      $display("FAIL flag_clear: flags %b expected 1101", flags);
    else n_pass++;
    quiesce();
  endtask

  // width=100, reset at count 50 discards the partial count
  task automatic test_reset_midcount();
    logic [CH-1:0] seen;
    seen  = '0;
    width = CW'(1);
    dirty = 4'b0100;
    repeat (4) tick();
    width = CW'(100);
    dirty = 4'b0101;
    repeat (52) tick();
    n_total++;
    if (clean !== 4'b0100 || flags !== 4'b0100)
      $display("FAIL premid_state: clean %b flags %b expected 0100 0100", clean, flags);
    else n_pass++;
    rst_n     = 1'b0;
    dirty     = 4'b0000;
    clr_flags = 4'b0000;
    tick();
    n_total++;
    if ({clean, rise, fall, flags, any_edge} !== 17'h0)
      $display("FAIL midcount_reset: got %h expected %h", {clean, rise, fall, flags, any_edge}, 17'h0);
    else n_pass++;
    rst_n = 1'b1;
    repeat (10) begin tick(); seen |= rise | fall; end
    n_total++;
    if (clean !== 4'b0000 || seen !== 4'b0000 || flags !== 4'b0000)
      $display("FAIL post_reset_quiet: clean %b edges %b flags %b expected 0000 0000 0000",
               clean, seen, flags);
    else n_pass++;
  endtask

  // en=0 freezes clean and pulses; re-enable restarts the count from zero
  task automatic test_enable();
    logic [CH-1:0] seen;
    logic          any_seen;
    seen     = '0;
    any_seen = 1'b0;
    quiesce();
    width = CW'(2);
    en    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      dirty[3] = ~dirty[3];
      tick();
      seen     |= rise | fall;
      any_seen |= any_edge;
    end
    dirty = 4'b1000;
    repeat (3) begin tick(); seen |= rise | fall; any_seen |= any_edge; end
    n_total++;
    if (clean !== 4'b0000 || seen !== 4'b0000 || any_seen !== 1'b0)
      $display("FAIL en_freeze: clean %b edges %b any %b expected 0000 0000 0", clean, seen, any_seen);
    else n_pass++;
    en = 1'b1;
    tick();
    n_total++;
    if (clean !== 4'b0000)
      $display("FAIL en_restart_early: clean %b expected 0000", clean);
    else n_pass++;
    tick();
    n_total++;
    if (clean !== 4'b1000 || rise !== 4'b1000)
      $display("FAIL en_restart_edge2: clean %b rise %b expected 1000 1000", clean, rise);
    else n_pass++;
    en        = 1'b0;
    clr_flags = 4'b1000;
    tick();
    clr_flags = 4'b0000;
    n_total++;
    if (flags !== 4'b0000 || clean !== 4'b1000)
      $display("FAIL en_clr_flags: flags %b clean %b expected 0000 1000", flags, clean);
    else n_pass++;
    quiesce();
  endtask

  // lowering the threshold mid-count accepts on the next edge; raising extends
  task automatic test_width_change();
    width = CW'(10);
    dirty = 4'b0010;
    repeat (7) tick();
    n_total++;
    if (clean !== 4'b0000)
      $display("FAIL wchg_before: clean %b expected 0000", clean);
    else n_pass++;
    width = CW'(3);
    tick();
    n_total++;
    if (clean !== 4'b0010 || rise !== 4'b0010)
      $display("FAIL wchg_decrease: clean %b rise %b expected 0010 0010", clean, rise);
    else n_pass++;
    tick();
    n_total++;
    if (rise !== 4'b0000 || any_edge !== 1'b0)
      $display("FAIL wchg_single_pulse: rise %b any %b expected 0000 0", rise, any_edge);
    else n_pass++;
    dirty = 4'b0000;
    repeat (3) tick();
    width = CW'(5);
    repeat (2) tick();
    n_total++;
    if (clean !== 4'b0010 || fall !== 4'b0000)
      $display("FAIL wchg_increase_hold: clean %b fall %b expected 0010 0000", clean, fall);
    else n_pass++;
    repeat (2) tick();
    n_total++;
    if (clean !== 4'b0000 || fall !== 4'b0010)
      $display("FAIL wchg_increase_edge: clean %b fall %b expected 0000 0010", clean, fall);
    else n_pass++;
    quiesce();
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    width     = CW'(4);
    dirty     = '0;
    clr_flags = '0;

    test_reset();
    test_basic_rise();
    test_glitch();
    test_width_zero_one();
    test_simultaneous_flags();
    test_width_change();
    test_reset_midcount();
    test_enable();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_debounce_bank
`default_nettype wire

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent debounced inputs, legal range 1..32.
REQ-002 Parameter CNT_W, default 24: width of the stability threshold and of each per-channel counter.
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-004 Parameter RESET_VAL, default all-zero, CHANNELS bits: reset level of clean and of every synchroniser stage, per channel.
REQ-005 Port clk  input  1: sole clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1: reset, synchronous, active-low.
REQ-007 Port en  input  1: debounce enable; low freezes filtering.
REQ-008 Port width  input  CNT_W: required count of consecutive differing cycles; 0 treated as 1.
REQ-009 Port dirty  input  CHANNELS: raw asynchronous inputs, one bit per channel.
REQ-010 Port clean  output  CHANNELS: debounced levels, registered.
REQ-011 Port rise  output  CHANNELS: one-cycle pulse when clean[i] goes 0->1, registered.
REQ-012 Port fall  output  CHANNELS: one-cycle pulse when clean[i] goes 1->0, registered.
REQ-013 Port flags  output  CHANNELS: sticky per-channel edge-seen status.
REQ-014 Port clr_flags  input  CHANNELS: per-bit clear for flags.
REQ-015 Port any_edge  output  1: registered OR of all rise and fall bits, same cycle as the pulses.

Function
REQ-016 Each channel SHALL pass dirty[i] through a SYNC_STAGES flop chain; s[i] denotes the final-stage output.
REQ-017 Each channel SHALL hold a CNT_W-bit counter cnt[i]; W_eff = (width == 0) ? 1 : width.
REQ-018 Per channel, each edge with en=1: if s[i]==clean[i] then cnt[i]<=0; else if cnt[i] >= W_eff-1 then clean[i]<=s[i], cnt[i]<=0; else cnt[i]<=cnt[i]+1.
REQ-019 clean[i] SHALL update only after s[i] differs from clean[i] for W_eff consecutive enabled cycles; any single matching cycle restarts the count at 0.
REQ-020 Latency: a clean dirty step reaches clean SYNC_STAGES + W_eff rising edges after the edge first sampling it.
REQ-021 rise[i]/fall[i] SHALL assert in the same cycle clean[i] first shows the new value and deassert the next cycle; never both set.
REQ-022 The >= compare SHALL make a width decrease mid-count update on the next edge if cnt[i] already meets the new threshold; a width increase extends the count.
REQ-023 cnt[i] SHALL never wrap; the update at W_eff-1 bounds it below 2^CNT_W - 1.
REQ-024 en=0: cnt all held at 0, clean held, rise/fall/any_edge 0, synchroniser keeps running, flags still clearable.
REQ-025 On en 0->1, counting SHALL restart from 0 on the first enabled cycle.
REQ-026 flags[i] SHALL set on the edge where rise[i] or fall[i] becomes 1 and clear on an edge with clr_flags[i]=1; simultaneous set and clear SHALL leave flags[i]=1.
REQ-027 Channels SHALL be fully independent; simultaneous updates on multiple channels SHALL all take effect in the same cycle.

Reset
REQ-028 rst_n=0 sampled on a rising edge SHALL set clean=RESET_VAL, all synchroniser stages=RESET_VAL, cnt=0, rise=fall=0, flags=0, any_edge=0.
REQ-029 Reset mid-count SHALL discard the partial count with no pulse; dirty held at RESET_VAL after release produces no edge.
REQ-030 Reset SHALL dominate en, clr_flags and all other inputs.

Verification
REQ-031 CHANNELS=4, SYNC_STAGES=2, width=4, en=1, dirty[0] 0->1 held -> clean[0]=1 and rise[0]=1 for one cycle exactly 6 edges later; flags[0]=1, any_edge=1 that cycle.
REQ-032 width=4, dirty[1] high for 3 cycles then low -> clean[1] stays 0, no rise/fall, cnt[1] returns to 0.
REQ-033 width=0 and width=1, dirty[2] step -> clean[2] updates SYNC_STAGES+1 edges later in both cases.
REQ-034 dirty[3:0] all step simultaneously, width=2 -> all four rise bits assert in the same cycle; then clr_flags=4'b0001 same cycle as fall[0] -> flags[0] stays 1.
REQ-035 width=100, rst_n=0 at count 50 -> outputs return to RESET_VAL/0 next edge, no pulse; en=0 with dirty toggling -> clean frozen, no pulses.
REQ-036 width 10 -> 3 at cnt=5 -> clean updates on the next edge with a single pulse.
